// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encoding, default
// frame marker and the inter-byte timeout sizing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // One byte on the line is 10 bit times (start + 8 data + stop).
  function automatic int unsigned to_cyc(input int unsigned clk_freq,
                                         input int unsigned baud_rate,
                                         input int unsigned timeout_bytes);
    return (timeout_bytes * 32'd10 * clk_freq) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 register file, one synchronous write port and one
// asynchronous read port.
module uart_pkt_buf
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // Contents need no reset: the controller only reads entries it has written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frame controller behind the UART byte receiver: parses SYNC/LEN/payload/CHK
// frames, buffers the payload and replays it on a valid/ready stream.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC,
  parameter int unsigned TIMEOUT_BYTES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_tmo,
  output logic       err_ovr,
  output logic       busy
);

  localparam int unsigned TO_CYC = to_cyc(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TO_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] rd_nxt_s;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       pkt_data_q, pkt_data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_last_q, pkt_last_d;
  logic             frame_ok_q, frame_ok_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovr_q, err_ovr_d;
  logic             busy_q, busy_d;
  logic             in_frame_s, tmo_hit_s, xfer_s, buf_we_s;
  logic [7:0]       buf_rdata_s;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we_s),
    .waddr (wr_idx_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_nxt_s[AW-1:0]),
    .rdata (buf_rdata_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    chk_d       = chk_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_last_d  = pkt_last_q;
    frame_ok_d  = 1'b0;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    err_ovr_d   = 1'b0;
    buf_we_s    = 1'b0;
    xfer_s      = pkt_valid_q & pkt_ready;

    // The read address always points at the byte to present next, so it never
    // runs past the last written entry.
    if (state_q == ST_CHK) begin
      rd_nxt_s = '0;
    end else if (pkt_last_q) begin
      rd_nxt_s = rd_idx_q;
    end else begin
      rd_nxt_s = rd_idx_q + IDX_ONE;
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    in_frame_s = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    tmo_hit_s  = in_frame_s && !rx_ready && (tmo_q == TMO_LAST);
    if (in_frame_s && !rx_ready && !tmo_hit_s) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_ready && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rx_ready) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d    = rx_data[IDX_W-1:0];
            chk_d    = rx_data;
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (rx_ready) begin
          buf_we_s = 1'b1;
          chk_d    = chk_q ^ rx_data;
          if (wr_idx_q == (len_q - IDX_ONE)) begin
            state_d = ST_CHK;
          end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
          end
        end else if (tmo_hit_s) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (rx_ready) begin
          if (rx_data == chk_q) begin
            frame_ok_d  = 1'b1;
            rd_idx_d    = '0;
            pkt_valid_d = 1'b1;
            pkt_data_d  = buf_rdata_s;
            pkt_last_d  = (len_q == IDX_ONE);
            state_d     = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_DRAIN: begin
        err_ovr_d = rx_ready;
        if (xfer_s && pkt_last_q) begin
          pkt_valid_d = 1'b0;
          pkt_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (xfer_s) begin
          rd_idx_d   = rd_nxt_s;
          pkt_data_d = buf_rdata_s;
          pkt_last_d = (rd_nxt_s == (len_q - IDX_ONE));
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        pkt_valid_d = 1'b0;
        pkt_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      chk_q       <= 8'd0;
      tmo_q       <= '0;
      pkt_data_q  <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      frame_ok_q  <= frame_ok_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= err_ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_last  = pkt_last_q;
  assign frame_ok  = frame_ok_q;
  assign err_chk   = err_chk_q;
  assign err_len   = err_len_q;
  assign err_tmo   = err_tmo_q;
  assign err_ovr   = err_ovr_q;
  assign busy      = busy_q;

endmodule
